// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target receiver: word width, FSM encoding
// and the level miso rests at while the target is deselected.
package spi_pkg;

    localparam int SPI_WORD_W = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    localparam logic SPI_MISO_IDLE = 1'b1;

endpackage : spi_pkg

// File: rtl/spi_sync.sv
// Multi-stage flip-flop synchronizer for one asynchronous input bit; the
// reset level is supplied by the instantiating logic.
module spi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rst_val_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{rst_val_i}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule : spi_sync

// File: rtl/spi_slave_rx.sv
// SPI target: sclk idles high, mosi sampled on rising sclk, LSB first.
// Received words leave on a valid/ready port; miso is fed from a one-deep holding register.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_WIDTH  = SPI_WORD_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sclk_i,
    input  logic                  mosi_i,
    input  logic                  cs_n_i,
    output logic                  miso_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic                  overrun_o,
    output logic                  busy_o
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic sync_sclk, sync_mosi, sync_cs_n;
    logic sclk_rise, sclk_fall, cs_start, cs_end;

    spi_state_e state_q, state_d;

    logic                  sclk_q, cs_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    // Holds only the bits already received; the final bit is taken straight from mosi.
    logic [DATA_WIDTH-2:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic                  miso_q, miso_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  overrun_q, overrun_d;

    logic [DATA_WIDTH-1:0] rx_word;
    logic                  rx_accept, tx_write, reload, word_done;

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk_i(clk_i), .rst_i(rst_i), .rst_val_i(1'b1), .d_i(sclk_i), .q_o(sync_sclk)
    );
    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk_i(clk_i), .rst_i(rst_i), .rst_val_i(1'b1), .d_i(mosi_i), .q_o(sync_mosi)
    );
    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs_n (
        .clk_i(clk_i), .rst_i(rst_i), .rst_val_i(1'b1), .d_i(cs_n_i), .q_o(sync_cs_n)
    );

    assign sclk_rise = sync_sclk & ~sclk_q;
    assign sclk_fall = ~sync_sclk & sclk_q;
    assign cs_start  = ~sync_cs_n & cs_q;
    assign cs_end    = sync_cs_n & ~cs_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_start) state_d = ACTIVE;
            ACTIVE:  if (cs_end)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q == ACTIVE);
    end

    assign rx_word   = {sync_mosi, rx_shift_q};
    assign rx_accept = rx_valid_q & rx_ready_i;
    assign tx_write  = tx_valid_i & ~hold_full_q;

    always_comb begin
        cnt_d       = cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        miso_d      = miso_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
        reload      = 1'b0;
        word_done   = 1'b0;

        if (rx_accept) rx_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_start) begin
                    cnt_d  = '0;
                    reload = 1'b1;
                end
            end
            ACTIVE: begin
                if (sclk_fall) begin
                    miso_d     = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                end
                // A rise coincident with deselect still completes its word, but the
                // holding register is not consumed by a frame that is ending.
                if (sclk_rise) begin
                    rx_shift_d = rx_word[DATA_WIDTH-1:1];
                    if (cnt_q == LAST_BIT) begin
                        word_done = 1'b1;
                        cnt_d     = '0;
                        reload    = ~cs_end;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                if (cs_end) begin
                    cnt_d  = '0;
                    miso_d = SPI_MISO_IDLE;
                end
            end
            default: ;
        endcase

        if (reload) begin
            tx_shift_d  = hold_full_q ? hold_q : '0;
            hold_full_d = 1'b0;
        end
        if (tx_write) begin
            hold_d      = tx_data_i;
            hold_full_d = 1'b1;
        end

        if (word_done) begin
            if (!rx_valid_q || rx_accept) begin
                rx_data_d  = rx_word;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_q      <= 1'b1;
            cs_q        <= 1'b1;
            cnt_q       <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            miso_q      <= SPI_MISO_IDLE;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sclk_q      <= sync_sclk;
            cs_q        <= sync_cs_n;
            cnt_q       <= cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            miso_q      <= miso_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign miso_o     = miso_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign tx_ready_o = ~hold_full_q;
    assign overrun_o  = overrun_q;

endmodule : spi_slave_rx

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: a simple SPI master drives frames and
// received words, miso bits and flags are compared with hand-computed values.
module tb_spi_slave_rx;

    localparam int HALF    = 10;
    localparam int LATENCY = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b1;
    logic       mosi = 1'b1;
    logic       csN = 1'b1;
    logic       miso;
    logic [7:0] rxData;
    logic       rxValid;
    logic       rxReady = 1'b1;
    logic [7:0] txData = 8'h00;
    logic       txValid = 1'b0;
    logic       txReady;
    logic       overrun;
    logic       busy;

    int assertCnt = 0;
    int failCnt   = 0;
    int cycleCnt  = 0;
    int lastRiseCycle = 0;
    int validCycle = -1;
    logic prevValid = 1'b0;
    logic [7:0] accQ[$];
    logic [7:0] misoWord, misoWord2;
    int base;

    spi_slave_rx #(.SYNC_STAGES(2), .DATA_WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst), .sclk_i(sclk), .mosi_i(mosi), .cs_n_i(csN),
        .miso_o(miso), .rx_data_o(rxData), .rx_valid_o(rxValid), .rx_ready_i(rxReady),
        .tx_data_i(txData), .tx_valid_i(txValid), .tx_ready_o(txReady),
        .overrun_o(overrun), .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Words the consumer actually takes, in order.
    always @(posedge clk) begin
        if (!rst && rxValid && rxReady) accQ.push_back(rxData);
    end

    always @(negedge clk) begin
        if (rxValid && !prevValid) validCycle = cycleCnt;
        prevValid = rxValid;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCnt++;
        if (observed !== expected) begin
            failCnt++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Clocks out nbits of data LSB first, capturing miso at each rising sclk.
    task automatic applyStimulus(input logic [7:0] data, input int nbits, output logic [7:0] mWord);
        mWord = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            sclk = 1'b0;
            mosi = data[i];
            repeat (HALF) @(negedge clk);
            mWord[i] = miso;
            sclk = 1'b1;
            lastRiseCycle = cycleCnt;
            repeat (HALF - 1) @(negedge clk);
        end
    endtask

    task automatic setCs(input logic level);
        @(negedge clk);
        csN = level;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_miso", miso, 1);
        checkOutput("reset_rx_data", rxData, 8'h00);
        checkOutput("reset_rx_valid", rxValid, 0);
        checkOutput("reset_tx_ready", txReady, 1);
        checkOutput("reset_overrun", overrun, 0);
        checkOutput("reset_busy", busy, 0);

        // Single word 0xA5
        setCs(1'b0);
        checkOutput("t1_busy_active", busy, 1);
        validCycle = -1;
        applyStimulus(8'hA5, 8, misoWord);
        checkOutput("t1_latency", validCycle - lastRiseCycle, LATENCY);
        setCs(1'b1);
        checkOutput("t1_count", accQ.size(), 1);
        if (accQ.size() >= 1) checkOutput("t1_data", accQ[0], 8'hA5);
        checkOutput("t1_overrun", overrun, 0);
        checkOutput("t1_busy_idle", busy, 0);
        checkOutput("t1_miso_idle", miso, 1);

        // Transmit 0x3C from the holding register
        @(negedge clk);
        txData = 8'h3C;
        txValid = 1'b1;
        @(negedge clk);
        txValid = 1'b0;
        checkOutput("t2_tx_ready_full", txReady, 0);
        setCs(1'b0);
        checkOutput("t2_tx_ready_loaded", txReady, 1);
        applyStimulus(8'h00, 8, misoWord);
        checkOutput("t2_miso_word", misoWord, 8'h3C);
        setCs(1'b1);
        checkOutput("t2_count", accQ.size(), 2);
        if (accQ.size() >= 2) checkOutput("t2_data", accQ[1], 8'h00);

        // Back-to-back words in one frame
        base = accQ.size();
        setCs(1'b0);
        applyStimulus(8'h12, 8, misoWord);
        applyStimulus(8'h34, 8, misoWord2);
        setCs(1'b1);
        checkOutput("t3_count", accQ.size() - base, 2);
        if (accQ.size() >= base + 2) begin
            checkOutput("t3_first", accQ[base], 8'h12);
            checkOutput("t3_second", accQ[base + 1], 8'h34);
        end
        checkOutput("t3_miso_first", misoWord, 8'h00);
        checkOutput("t3_miso_second", misoWord2, 8'h00);

        // Overrun with consumer stalled
        base = accQ.size();
        @(negedge clk);
        rxReady = 1'b0;
        setCs(1'b0);
        applyStimulus(8'h55, 8, misoWord);
        repeat (5) @(negedge clk);
        checkOutput("t4_overrun_before", overrun, 0);
        applyStimulus(8'hAA, 8, misoWord);
        setCs(1'b1);
        checkOutput("t4_rx_data_kept", rxData, 8'h55);
        checkOutput("t4_rx_valid_held", rxValid, 1);
        checkOutput("t4_overrun_set", overrun, 1);
        repeat (20) @(negedge clk);
        checkOutput("t4_overrun_sticky", overrun, 1);
        checkOutput("t4_no_accept", accQ.size() - base, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rxReady = 1'b1;
        checkOutput("t4_overrun_cleared", overrun, 0);
        checkOutput("t4_valid_cleared", rxValid, 0);
        repeat (4) @(negedge clk);

        // Partial word discarded, then full 0x81
        base = accQ.size();
        setCs(1'b0);
        applyStimulus(8'hFF, 5, misoWord);
        setCs(1'b1);
        repeat (5) @(negedge clk);
        checkOutput("t5_no_partial", accQ.size() - base, 0);
        checkOutput("t5_valid_low", rxValid, 0);
        setCs(1'b0);
        applyStimulus(8'h81, 8, misoWord);
        setCs(1'b1);
        checkOutput("t5_count", accQ.size() - base, 1);
        if (accQ.size() >= base + 1) checkOutput("t5_data", accQ[base], 8'h81);

        // Reset mid-transfer, then 0xC3
        setCs(1'b0);
        applyStimulus(8'hFF, 3, misoWord);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("t6_rx_data_reset", rxData, 8'h00);
        checkOutput("t6_busy_reset", busy, 0);
        checkOutput("t6_miso_reset", miso, 1);
        checkOutput("t6_tx_ready_reset", txReady, 1);
        checkOutput("t6_overrun_reset", overrun, 0);
        setCs(1'b1);
        base = accQ.size();
        setCs(1'b0);
        applyStimulus(8'hC3, 8, misoWord);
        setCs(1'b1);
        checkOutput("t6_count", accQ.size() - base, 1);
        if (accQ.size() >= base + 1) checkOutput("t6_data", accQ[base], 8'hC3);
        checkOutput("t6_overrun", overrun, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule : tb_spi_slave_rx
